// File: rtl/cp0_if.sv
// CP0 bus: M-stage exception inputs, mfc0/mtc0/eret access, and redirect/EPC outputs.
interface cp0_if;
  logic [4:0]  errorcode_M;
  logic [31:0] pc_M;
  logic        bd_M;
  logic [5:0]  hwint;
  logic        we_M;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        eret_M;
  logic [31:0] dout;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output errorcode_M, pc_M, bd_M, hwint, we_M, addr, din, eret_M,
    input  dout, req, handler_pc, epc_out
  );

  modport slave (
    input  errorcode_M, pc_M, bd_M, hwint, we_M, addr, din, eret_M,
    output dout, req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR/Cause/EPC/PRId) with M-stage exception/interrupt arbitration.
module cp0_unit #(
  parameter logic [4:0]  NONE_CODE  = 5'd31,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2021_0601
) (
  input logic  clk,
  input logic  rst_n,
  cp0_if.slave bus
);
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req  = (|(bus.hwint & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req  = (bus.errorcode_M != NONE_CODE) & ~sr_exl;
  assign req      = int_req | exc_req;
  assign epc_next = bus.bd_M ? (bus.pc_M - 32'd4) : bus.pc_M;

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hwint;
      if (req) begin
        // A taken request overrides both eret and any coincident mtc0.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : bus.errorcode_M;
        cause_bd  <= bus.bd_M;
        epc       <= {epc_next[31:2], 2'b00};
      end else begin
        if (bus.eret_M)
          sr_exl <= 1'b0;
        if (bus.we_M) begin
          case (bus.addr)
            5'd12: begin
              sr_im  <= bus.din[15:10];
              sr_exl <= bus.din[1];
              sr_ie  <= bus.din[0];
            end
            5'd14:   epc <= {bus.din[31:2], 2'b00};
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      5'd12:   bus.dout = sr_val;
      5'd13:   bus.dout = cause_val;
      5'd14:   bus.dout = epc;
      5'd15:   bus.dout = PRID;
      default: bus.dout = '0;
    endcase
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.epc_out    = epc;
endmodule
